// File: rtl/cv32e40p_rf_ctx_pkg.sv
// Shared types and checksum helper for the register-file context sequencer.
// The CFI check logic reuses the same rotate-XOR checksum function.
package cv32e40p_rf_ctx_pkg;

  localparam int unsigned CSUM_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SAVE,
    RESTORE,
    DONE
  } rf_ctx_state_e;

  typedef enum logic {
    DIR_SAVE,
    DIR_RESTORE
  } rf_ctx_dir_e;

  // Rotate left by one, then fold in the new word.
  function automatic logic [CSUM_WIDTH-1:0] csum_update(
    input logic [CSUM_WIDTH-1:0] csum,
    input logic [CSUM_WIDTH-1:0] data
  );
    return {csum[CSUM_WIDTH-2:0], csum[CSUM_WIDTH-1]} ^ data;
  endfunction

endpackage

// File: rtl/cv32e40p_rf_ctx_chk.sv
// Running rotate-XOR checksum register with clear and update enables.
// The clear input takes priority over update.
module cv32e40p_rf_ctx_chk
  import cv32e40p_rf_ctx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  update,
  input  logic [CSUM_WIDTH-1:0] data,
  output logic [CSUM_WIDTH-1:0] checksum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (clear) begin
      checksum <= '0;
    end else if (update) begin
      checksum <= csum_update(checksum, data);
    end
  end

endmodule

// File: rtl/cv32e40p_rf_ctx_seq.sv
// Saves or restores x1..x31 over valid/ready streams while holding the core off
// the register file, accumulating a checksum of every transferred word.
module cv32e40p_rf_ctx_seq
  import cv32e40p_rf_ctx_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  save_req_i,
  input  logic                  restore_req_i,
  input  logic                  core_idle_i,
  output logic                  stall_core_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] checksum_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_we_o,
  output logic                  sv_valid_o,
  input  logic                  sv_ready_i,
  output logic [DATA_WIDTH-1:0] sv_data_o,
  output logic [ADDR_WIDTH-1:0] sv_idx_o,
  input  logic                  rs_valid_i,
  output logic                  rs_ready_o,
  input  logic [DATA_WIDTH-1:0] rs_data_i
);

  if (LAST_REG < FIRST_REG) begin : g_bad_range
    $error("cv32e40p_rf_ctx_seq: LAST_REG must be >= FIRST_REG");
  end
  if (DATA_WIDTH != CSUM_WIDTH) begin : g_bad_width
    $error("cv32e40p_rf_ctx_seq: DATA_WIDTH must match the checksum width");
  end

  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(LAST_REG);

  rf_ctx_state_e         state;
  rf_ctx_dir_e           dir;
  logic [ADDR_WIDTH-1:0] counter;

  logic                  in_save;
  logic                  in_restore;
  logic                  xfer;
  logic                  leave_idle;
  logic [DATA_WIDTH-1:0] xfer_data;

  assign in_save    = (state == SAVE);
  assign in_restore = (state == RESTORE);
  assign xfer       = (in_save & sv_ready_i) | (in_restore & rs_valid_i);
  assign xfer_data  = in_save ? rf_rdata_i : rs_data_i;
  assign leave_idle = (state == IDLE) & (save_req_i | restore_req_i);

  // Requests are only looked at in IDLE; save has priority over restore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir     <= DIR_SAVE;
      counter <= FIRST;
    end else begin
      case (state)
        IDLE: begin
          if (save_req_i) begin
            dir     <= DIR_SAVE;
            state   <= DRAIN;
            counter <= FIRST;
          end else if (restore_req_i) begin
            dir     <= DIR_RESTORE;
            state   <= DRAIN;
            counter <= FIRST;
          end
        end
        DRAIN: begin
          if (core_idle_i) begin
            state <= (dir == DIR_SAVE) ? SAVE : RESTORE;
          end
        end
        SAVE, RESTORE: begin
          if (xfer) begin
            if (counter == LAST) begin
              state <= DONE;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  cv32e40p_rf_ctx_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (leave_idle),
    .update   (xfer),
    .data     (xfer_data),
    .checksum (checksum_o)
  );

  // Every datapath output is gated by its state so idle outputs read as zero.
  assign busy_o       = (state == DRAIN) | in_save | in_restore;
  assign stall_core_o = busy_o;
  assign done_o       = (state == DONE);

  assign rf_raddr_o   = in_save ? counter : '0;
  assign sv_valid_o   = in_save;
  assign sv_data_o    = in_save ? rf_rdata_i : '0;
  assign sv_idx_o     = in_save ? counter : '0;

  assign rs_ready_o   = in_restore;
  assign rf_we_o      = in_restore & rs_valid_i;
  assign rf_waddr_o   = in_restore ? counter : '0;
  assign rf_wdata_o   = in_restore ? rs_data_i : '0;

endmodule

// File: tb/tb_cv32e40p_rf_ctx_seq.sv
// Directed bench for the register-file context sequencer with a simple
// register-file model behind the read and write ports.
module tb_cv32e40p_rf_ctx_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        save_req = 1'b0;
  logic        restore_req = 1'b0;
  logic        core_idle = 1'b0;
  logic        stall_core, busy, done;
  logic [31:0] checksum;
  logic [4:0]  rf_raddr, rf_waddr, sv_idx;
  logic [31:0] rf_rdata, rf_wdata, sv_data;
  logic        rf_we, sv_valid, rs_ready;
  logic        sv_ready = 1'b0;
  logic        rs_valid = 1'b0;
  logic [31:0] rs_data = '0;

  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] rf [32];

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] csumRef;
  logic [31:0] csumNow;

  always #5 clk = ~clk;

  cv32e40p_rf_ctx_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .save_req_i    (save_req),
    .restore_req_i (restore_req),
    .core_idle_i   (core_idle),
    .stall_core_o  (stall_core),
    .busy_o        (busy),
    .done_o        (done),
    .checksum_o    (checksum),
    .rf_raddr_o    (rf_raddr),
    .rf_rdata_i    (rf_rdata),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .rf_we_o       (rf_we),
    .sv_valid_o    (sv_valid),
    .sv_ready_i    (sv_ready),
    .sv_data_o     (sv_data),
    .sv_idx_o      (sv_idx),
    .rs_valid_i    (rs_valid),
    .rs_ready_o    (rs_ready),
    .rs_data_i     (rs_data)
  );

  // x0 is deliberately writable here so a stray write to it is visible.
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = rf[rf_raddr];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rotXor(input logic [31:0] c, input logic [31:0] d);
    return {c[30:0], c[31]} ^ d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic preloadRegs();
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      pre_we   = 1'b1;
      pre_addr = 5'(i);
      pre_data = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Runs one full sequence from IDLE. pattern 0: full rate, 1: ready toggles,
  // 2: rs_valid drops every third cycle. bothReq raises both requests at once.
  task automatic applyStimulus(input string tag, input bit isSave, input bit bothReq,
                               input int pattern, input int idleDelay, input bit injectRestore,
                               output logic [31:0] csumOut);
    int idx = 1;
    int cyc = 0;
    int dones = 0;
    int xfers = 0;
    int firstValid = -1;
    int doneCyc = -1;
    bit holdPending = 1'b0;
    logic [31:0] lastData = '0;
    logic [4:0]  lastIdx = '0;
    logic [31:0] csum = '0;
    while (dones == 0 && cyc < 400) begin
      @(posedge clk); #1;
      save_req    = (cyc == 0) && (isSave || bothReq);
      restore_req = ((cyc == 0) && (!isSave || bothReq)) || (injectRestore && cyc >= 8 && cyc < 20);
      core_idle   = (cyc > idleDelay);
      sv_ready    = (pattern == 1) ? (cyc % 2 == 0) : 1'b1;
      rs_valid    = (pattern == 2) ? (cyc % 3 != 2) : 1'b1;
      rs_data     = 32'hA5A5_0000 + 32'(idx);
      #1;
      if (cyc >= 1 && cyc <= idleDelay) begin
        checkOutput($sformatf("%s drain stall c%0d", tag, cyc), {31'b0, stall_core}, 32'd1);
        checkOutput($sformatf("%s drain quiet c%0d", tag, cyc), {30'b0, sv_valid, rs_ready}, 32'd0);
      end
      if (isSave) begin
        checkOutput($sformatf("%s no rs activity c%0d", tag, cyc), {30'b0, rs_ready, rf_we}, 32'd0);
        if (sv_valid) begin
          if (firstValid < 0) firstValid = cyc;
          checkOutput($sformatf("%s sv_idx c%0d", tag, cyc), {27'b0, sv_idx}, 32'(idx));
          checkOutput($sformatf("%s sv_data x%0d", tag, idx), sv_data, 32'h1000_0000 + 32'(idx));
          if (holdPending) begin
            checkOutput($sformatf("%s hold data c%0d", tag, cyc), sv_data, lastData);
            checkOutput($sformatf("%s hold idx c%0d", tag, cyc), {27'b0, sv_idx}, {27'b0, lastIdx});
          end
          if (sv_ready) begin
            csum = rotXor(csum, 32'h1000_0000 + 32'(idx));
            idx++;
            xfers++;
            holdPending = 1'b0;
          end else begin
            holdPending = 1'b1;
            lastData = sv_data;
            lastIdx = sv_idx;
          end
        end
      end else begin
        checkOutput($sformatf("%s no sv activity c%0d", tag, cyc), {31'b0, sv_valid}, 32'd0);
        if (rs_ready) begin
          checkOutput($sformatf("%s we follows valid c%0d", tag, cyc), {31'b0, rf_we}, {31'b0, rs_valid});
          if (rs_valid) begin
            checkOutput($sformatf("%s waddr c%0d", tag, cyc), {27'b0, rf_waddr}, 32'(idx));
            csum = rotXor(csum, 32'hA5A5_0000 + 32'(idx));
            idx++;
            xfers++;
          end
        end else begin
          checkOutput($sformatf("%s we idle c%0d", tag, cyc), {31'b0, rf_we}, 32'd0);
        end
      end
      if (done) begin
        dones++;
        doneCyc = cyc;
        checkOutput($sformatf("%s checksum", tag), checksum, csum);
        checkOutput($sformatf("%s stall at done", tag), {30'b0, stall_core, busy}, 32'd0);
        checkOutput($sformatf("%s transfers", tag), 32'(xfers), 32'd31);
      end
      cyc++;
    end
    checkOutput($sformatf("%s done seen", tag), 32'(dones), 32'd1);
    if (isSave && pattern == 0) begin
      checkOutput($sformatf("%s consecutive words", tag), 32'(doneCyc - firstValid), 32'd31);
    end
    restore_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      checkOutput($sformatf("%s idle after done k%0d", tag, k), {30'b0, done, busy}, 32'd0);
      checkOutput($sformatf("%s checksum held k%0d", tag, k), checksum, csum);
    end
    csumOut = csum;
  endtask

  initial begin
    logic [31:0] csumModel;
    int waitCyc;
    rst_n = 1'b0;
    #3;
    checkOutput("reset ctl outputs", {26'b0, stall_core, busy, done, sv_valid, rs_ready, rf_we}, 32'd0);
    checkOutput("reset checksum", checksum, 32'd0);
    checkOutput("reset addrs", {17'b0, rf_raddr, rf_waddr, sv_idx}, 32'd0);
    #10 rst_n = 1'b1;
    preloadRegs();

    csumModel = '0;
    for (int i = 1; i <= 31; i++) csumModel = rotXor(csumModel, 32'h1000_0000 + 32'(i));

    // 1: full-rate save
    applyStimulus("save_full", 1'b1, 1'b0, 0, 0, 1'b0, csumRef);
    checkOutput("save_full independent csum", checksum, csumModel);

    // 2: back-pressured save gives the same checksum
    applyStimulus("save_bp", 1'b1, 1'b0, 1, 0, 1'b0, csumNow);
    checkOutput("save_bp csum vs full", checksum, csumModel);

    // 4: both requests with core busy for 5 cycles: save wins
    applyStimulus("both_req", 1'b1, 1'b1, 0, 5, 1'b0, csumNow);
    checkOutput("both_req csum", checksum, csumModel);

    // 6: restore request during a save is ignored
    applyStimulus("ignore_rs", 1'b1, 1'b0, 0, 0, 1'b1, csumNow);
    checkOutput("ignore_rs csum", checksum, csumModel);

    // 5: reset in the middle of a save
    @(posedge clk); #1;
    save_req  = 1'b1;
    core_idle = 1'b1;
    sv_ready  = 1'b1;
    @(posedge clk); #1;
    save_req = 1'b0;
    waitCyc = 0;
    while (!(sv_valid && sv_idx == 5'd10) && waitCyc < 100) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    checkOutput("reached word 10", {31'b0, sv_valid && sv_idx == 5'd10}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset ctl outputs", {26'b0, stall_core, busy, done, sv_valid, rs_ready, rf_we}, 32'd0);
    checkOutput("midreset checksum", checksum, 32'd0);
    checkOutput("midreset sv_data", sv_data, 32'd0);
    checkOutput("midreset addrs", {17'b0, rf_raddr, rf_waddr, sv_idx}, 32'd0);
    #12 rst_n = 1'b1;

    // 3: restore with valid gaps, after the reset
    applyStimulus("restore", 1'b0, 1'b0, 2, 0, 1'b0, csumNow);
    csumModel = '0;
    for (int i = 1; i <= 31; i++) csumModel = rotXor(csumModel, 32'hA5A5_0000 + 32'(i));
    checkOutput("restore csum model", checksum, csumModel);
    checkOutput("restore x0", rf[0], 32'd0);
    for (int i = 1; i <= 31; i++) begin
      checkOutput($sformatf("restore x%0d", i), rf[i], 32'hA5A5_0000 + 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rf_ctx_seq.md
Name: cv32e40p_rf_ctx_seq

Overview:
Sequencer that saves and restores the integer register file, walking x1..x31 for context switches and CFI checkpoints. On save it drives a regfile read port and streams each register out over a valid/ready interface. On restore it accepts a valid/ready stream and drives regfile write port B. While it runs, it holds the core stalled and keeps a running checksum of all transferred words for integrity checking.

Parameters:
ADDR_WIDTH, 5, regfile address width (integer bank only, bit 5 never set)
DATA_WIDTH, 32, register width
FIRST_REG, 1, first register index transferred (x0 is skipped)
LAST_REG, 31, last register index transferred

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
save_req_i  in  1  start save sequence (level; sampled in IDLE only)
restore_req_i  in  1  start restore sequence (level; sampled in IDLE only)
core_idle_i  in  1  core pipeline has no pending regfile writes
stall_core_o  out  1  holds the core off the regfile
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle completion pulse
checksum_o  out  DATA_WIDTH  running checksum; final value valid when done_o is high
rf_raddr_o  out  ADDR_WIDTH  regfile read address (port C)
rf_rdata_i  in  DATA_WIDTH  regfile read data (combinational from the FF regfile)
rf_waddr_o  out  ADDR_WIDTH  regfile write address (port B)
rf_wdata_o  out  DATA_WIDTH  regfile write data
rf_we_o  out  1  regfile write enable
sv_valid_o  out  1  save stream valid
sv_ready_i  in  1  save stream ready
sv_data_o  out  DATA_WIDTH  save stream data
sv_idx_o  out  ADDR_WIDTH  register index of the current save word
rs_valid_i  in  1  restore stream valid
rs_ready_o  out  1  restore stream ready
rs_data_i  in  DATA_WIDTH  restore stream data

Behaviour:
- Reset (rst_n is asynchronous, active-low; clock is clk):
  - state = IDLE; counter = FIRST_REG; checksum = 0.
  - All outputs are 0.
- States: IDLE, DRAIN, SAVE, RESTORE, DONE.
- IDLE:
  - If save_req_i is high: dir = SAVE, go to DRAIN.
  - Else if restore_req_i is high: dir = RESTORE, go to DRAIN.
  - Save wins when both requests are high in the same cycle.
  - On leaving IDLE: counter = FIRST_REG and checksum = 0.
- DRAIN:
  - stall_core_o = 1, busy_o = 1.
  - Wait for core_idle_i = 1, then go to SAVE or RESTORE on the next cycle.
- SAVE:
  - rf_raddr_o = counter; sv_valid_o = 1; sv_data_o = rf_rdata_i; sv_idx_o = counter.
  - On sv_valid_o & sv_ready_i:
    - checksum = {checksum[DW-2:0], checksum[DW-1]} ^ sv_data_o.
    - If counter == LAST_REG go to DONE, else counter increments.
  - sv_data_o and sv_idx_o stay stable while ready is low.
- RESTORE:
  - rs_ready_o = 1; rf_we_o = rs_valid_i; rf_waddr_o = counter; rf_wdata_o = rs_data_i.
  - On each accepted word, update the checksum with the same rotate-XOR rule and advance the counter as in SAVE.
  - The regfile write takes effect on the same clk edge as the handshake.
- DONE:
  - done_o = 1 for exactly one cycle; stall_core_o deasserts in the same cycle.
  - Next state is IDLE.
  - checksum_o holds its value until the next sequence starts.
- stall_core_o = busy_o = 1 in DRAIN, SAVE and RESTORE; both are 0 in IDLE and DONE.
- rf_we_o is 0 outside RESTORE. rs_ready_o and sv_valid_o are 0 outside their own states.
- Requests that arrive while not in IDLE are ignored; they are not queued.
- Throughput: one word per cycle when the stream is not back-pressured. A save of x1..x31 with sv_ready_i held high takes 31 SAVE cycles + 1 DONE cycle after DRAIN.
- Reset mid-operation aborts immediately to the reset state. Regfile contents already written are not rolled back.
- The counter never wraps. LAST_REG must be >= FIRST_REG, which is checked by an elaboration assertion.

Decomposition:
- Shared package cv32e40p_rf_ctx_pkg:
  - state enum rf_ctx_state_e {IDLE, DRAIN, SAVE, RESTORE, DONE};
  - direction enum;
  - checksum rotate-XOR function.
- Sub-module cv32e40p_rf_ctx_chk: the checksum register with clear and update enables, reused by the core's CFI check logic.

Test Plan:
1. Preload x1..x31 = 0x1000_0000 + i; save_req_i pulse; core_idle_i high; sv_ready_i always 1 -> sv_idx_o runs 1..31 on 31 consecutive cycles, each sv_data_o matches its register, done_o pulses once, checksum_o equals the model value.
2. Same save with sv_ready_i toggling 1/0 -> sv_data_o and sv_idx_o stay stable while ready is 0; 31 transfers total; same checksum as scenario 1.
3. Restore stream of 0xA5A5_0000 + i with rs_valid_i dropping every 3rd cycle -> x1..x31 hold the streamed values, x0 reads 0, rf_we_o asserts only on accepted words.
4. save_req_i and restore_req_i both high with core_idle_i low for 5 cycles -> stays in DRAIN with stall_core_o = 1 and no stream activity; after core_idle_i rises it performs a save.
5. rst_n asserted at save word 10 -> all outputs are 0 immediately; a new restore after reset completes normally.
6. restore_req_i asserted during a save -> ignored; only one done_o pulse, at the end of the save.
